// File: rtl/hp_write_arbiter.sv
// Two-requester single-beat AXI3 write arbiter with round-robin grant and per-requester outstanding limits.
// Optional error counter on non-OKAY write responses: define HP_WRITE_ARBITER_ERR_COUNT_EN.
module hp_write_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_data,
  input  logic [1:0][3:0]  req_strb,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [1:0]       rsp_resp,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      awaddr,
  output logic [5:0]       awid,
  output logic [3:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic [1:0]       awlock,
  output logic [3:0]       awcache,
  output logic [2:0]       awprot,
  output logic [3:0]       awqos,
  output logic             wvalid,
  input  logic             wready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wlast,
  output logic [5:0]       wid,
  input  logic             bvalid,
  output logic             bready,
  input  logic [5:0]       bid,
  input  logic [1:0]       bresp,
  output logic [7:0]       err_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state, state_next;
  logic            aw_pend, w_pend;
  logic [31:0]     hold_addr, hold_data;
  logic [3:0]      hold_strb;
  logic            hold_idx;
  logic            last_grant;
  logic [1:0][3:0] outstanding;
  logic [1:0]      eligible, grant, cnt_dec;
  logic            grant_idx, aw_done, w_done, b_hs;
  logic            bid_unused;

  assign bid_unused = ^bid[5:1];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++)
      eligible[i] = req_valid[i] && (outstanding[i] < MAX_CNT);
  end

  // Round-robin only matters when both are eligible; otherwise pass through the lone candidate.
  always_comb begin
    grant = '0;
    if (state == IDLE && !reset) begin
      if (eligible == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                   grant = eligible;
    end
  end

  assign grant_idx = grant[1];
  assign aw_done   = !aw_pend || awready;
  assign w_done    = !w_pend  || wready;
  assign b_hs      = bvalid && bready;
  assign cnt_dec   = {b_hs && bid[0], b_hs && !bid[0]};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|grant) state_next = ISSUE;
      ISSUE:   if (aw_done && w_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = grant;
    awvalid   = aw_pend;
    wvalid    = w_pend;
    awaddr    = hold_addr;
    wdata     = hold_data;
    wstrb     = hold_strb;
    awid      = {5'b0, hold_idx};
    wid       = {5'b0, hold_idx};
    wlast     = w_pend;
    awlen     = 4'b0000;
    awsize    = 3'b010;
    awburst   = 2'b01;
    awlock    = 2'b00;
    awcache   = 4'b0011;
    awprot    = 3'b000;
    awqos     = 4'b0000;
    rsp_valid = reset ? 2'b00 : {bvalid && bid[0], bvalid && !bid[0]};
    bready    = rsp_ready[bid[0]];
    rsp_resp  = bresp;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      last_grant <= 1'b1;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_strb  <= '0;
      hold_idx   <= 1'b0;
    end else if (|grant) begin
      hold_addr  <= req_addr[grant_idx];
      hold_data  <= req_data[grant_idx];
      hold_strb  <= req_strb[grant_idx];
      hold_idx   <= grant_idx;
      last_grant <= grant_idx;
      aw_pend    <= 1'b1;
      w_pend     <= 1'b1;
    end else begin
      if (aw_pend && awready) aw_pend <= 1'b0;
      if (w_pend  && wready)  w_pend  <= 1'b0;
    end
  end

  // A grant and a response on the same counter cancel out; an unmatched response saturates at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        unique case ({grant[i], cnt_dec[i]})
          2'b10:   outstanding[i] <= outstanding[i] + 4'd1;
          2'b01:   if (outstanding[i] != 4'd0) outstanding[i] <= outstanding[i] - 4'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef HP_WRITE_ARBITER_ERR_COUNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clock) begin
    if (reset)                                       err_q <= '0;
    else if (b_hs && bresp != 2'b00 && err_q != '1)  err_q <= err_q + 8'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_hp_write_arbiter.sv
// Directed bench for hp_write_arbiter, built with MAX_OUTSTANDING=2.
// Expected err_count follows HP_WRITE_ARBITER_ERR_COUNT_EN.
module tb_hp_write_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready;
  logic [1:0][31:0] req_addr, req_data;
  logic [1:0][3:0]  req_strb;
  logic [1:0]       rsp_valid, rsp_ready, rsp_resp;
  logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0]      awaddr, wdata;
  logic [5:0]       awid, wid, bid;
  logic [3:0]       awlen, awcache, awqos, wstrb;
  logic [2:0]       awsize, awprot;
  logic [1:0]       awburst, awlock, bresp;
  logic [7:0]       err_count;

  int n_cmp = 0;
  int n_bad = 0;

  hp_write_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_b(input logic [5:0] b, input logic [1:0] r);
    bvalid    = 1'b1;
    bid       = b;
    bresp     = r;
    rsp_ready = 2'b11;
    #1;
    check("b_rsp_valid", 32'(rsp_valid), b[0] ? 32'h2 : 32'h1);
    check("b_bready", 32'(bready), 32'h1);
    check("b_rsp_resp", 32'(rsp_resp), 32'(r));
    step();
    bvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b11; req_addr = '0; req_data = '0; req_strb = '0;
    rsp_ready = 2'b00; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bid = '0; bresp = 2'b00;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    check("rst_awvalid", 32'(awvalid), 32'h0);
    check("rst_wvalid", 32'(wvalid), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    reset = 1'b0; bvalid = 1'b0;

    // Continuous requests from both: grants alternate starting with requester 0.
    req_addr[0] = 32'hA000_0000; req_addr[1] = 32'hB000_0000;
    req_data[0] = 32'h1111_1111; req_data[1] = 32'h2222_2222;
    req_strb[0] = 4'hF;          req_strb[1] = 4'h3;
    awready = 1'b1; wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check("rr_awaddr", awaddr, (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000);
      check("rr_awid", 32'(awid), (k % 2 == 0) ? 32'h0 : 32'h1);
      step();
    end
    req_valid = 2'b00;

    // Drain both counters; the last response (bid=3 -> requester 1) arrives with a zero count.
    send_b(6'd0, 2'b00); send_b(6'd0, 2'b00);
    send_b(6'd1, 2'b00); send_b(6'd1, 2'b00);
    bvalid = 1'b1; bid = 6'd3; rsp_ready = 2'b01;
    #1;
    check("bready_route", 32'(bready), 32'h0);
    check("rsp_valid_route", 32'(rsp_valid), 32'h2);
    send_b(6'd3, 2'b00);

    // Single write from requester 0.
    req_valid = 2'b01; req_addr[0] = 32'h1000_0000; req_data[0] = 32'hDEAD_BEEF;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    #1;
    check("single_awvalid", 32'(awvalid), 32'h1);
    check("single_wvalid", 32'(wvalid), 32'h1);
    check("single_awaddr", awaddr, 32'h1000_0000);
    check("single_wdata", wdata, 32'hDEAD_BEEF);
    check("single_wstrb", 32'(wstrb), 32'hF);
    check("single_awid", 32'(awid), 32'h0);
    check("single_wid", 32'(wid), 32'h0);
    check("single_wlast", 32'(wlast), 32'h1);
    check("const_aw", {awlen, awsize, awburst, awlock, awcache, awprot, awqos},
          {4'h0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0});
    step();
    check("single_awvalid_drop", 32'(awvalid), 32'h0);
    check("single_wvalid_drop", 32'(wvalid), 32'h0);
    send_b(6'd0, 2'b00);

    // Requester 0 fills its limit of 2, is skipped, then regains eligibility after one response.
    req_valid = 2'b01;
    step(); step(); step(); step();
    check("limit_stall0", 32'(req_ready), 32'h0);
    req_valid = 2'b11;
    #1;
    check("limit_skip_to1", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    step();
    send_b(6'd0, 2'b00);
    req_valid = 2'b01;
    #1;
    check("limit_regrant0", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    step();
    send_b(6'd0, 2'b00);
    send_b(6'd1, 2'b00);

    // AW accepted three cycles late while W completes immediately.
    awready = 1'b0; wready = 1'b1;
    req_valid = 2'b01; req_addr[0] = 32'h2000_0040;
    #1;
    check("slow_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00; req_addr[0] = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("slow_awvalid", 32'(awvalid), 32'h1);
      check("slow_awaddr", awaddr, 32'h2000_0040);
      check("slow_wvalid", 32'(wvalid), (c == 1) ? 32'h1 : 32'h0);
      if (c == 4) awready = 1'b1;
      step();
    end
    check("slow_awvalid_drop", 32'(awvalid), 32'h0);
    req_valid = 2'b10;
    #1;
    check("slow_idle_again", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    step();

    // Error responses: three SLVERR and one OKAY.
    send_b(6'd0, 2'b10);
`ifdef HP_WRITE_ARBITER_ERR_COUNT_EN
    check("err_first", 32'(err_count), 32'd1);
`else
    check("err_first", 32'(err_count), 32'd0);
`endif
    send_b(6'd0, 2'b10);
    send_b(6'd1, 2'b10);
    send_b(6'd1, 2'b00);
`ifdef HP_WRITE_ARBITER_ERR_COUNT_EN
    check("err_total", 32'(err_count), 32'd3);
`else
    check("err_total", 32'(err_count), 32'd0);
`endif

    // Reset in the middle of an issue.
    awready = 1'b0; wready = 1'b0;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #1;
    check("mid_awvalid", 32'(awvalid), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_awvalid", 32'(awvalid), 32'h0);
    check("mid_rst_wvalid", 32'(wvalid), 32'h0);
    check("mid_rst_err", 32'(err_count), 32'h0);
    req_valid = 2'b11;
    #1;
    check("mid_rst_first0", 32'(req_ready), 32'h1);
    req_valid = 2'b01; awready = 1'b1; wready = 1'b1;
    step(); step();
    check("mid_rst_cnt_clear", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

endmodule
